// File: rtl/pipemdu_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide unit.
package pipemdu_pkg;

   localparam int MDU_XLEN = 32;

   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;

   localparam int MDU_ITER = 32;
   localparam int MDU_CNT_W = $clog2(MDU_ITER);

   localparam logic [MDU_XLEN-1:0] DIV0_Q = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/pipemdu_signfix.sv
// Conditional two's-complement negate; doubles as abs() when neg_i is the sign bit.
module pipemdu_signfix #(
   parameter int W = 32
) (
   input  logic [W-1:0] a_i,
   input  logic         neg_i,
   output logic [W-1:0] y_o
);

   assign y_o = neg_i ? ({W{1'b0}} - a_i) : a_i;

endmodule

// File: rtl/pipemdu.sv
// Iterative mult/multu/div/divu unit owning HI/LO; 32 CALC cycles plus one FIX cycle.
module pipemdu
   import pipemdu_pkg::*;
#(
   parameter int XLEN = MDU_XLEN
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            estart,
   input  logic [1:0]      eop,
   input  logic [XLEN-1:0] ea,
   input  logic [XLEN-1:0] eb,
   input  logic            ewhi,
   input  logic            ewlo,
   input  logic            dneed,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            busy,
   output logic            done,
   output logic            mdstall
);

   mdu_state_e             state_q;
   logic [MDU_CNT_W-1:0]   cnt_q;
   logic [2*XLEN-1:0]      prod_q;
   logic [XLEN-1:0]        rem_q;
   logic [XLEN-1:0]        quot_q;
   logic [XLEN-1:0]        opb_q;
   logic                   isdiv_q;
   logic                   negq_q;
   logic                   negr_q;
   logic                   div0_q;
   logic [XLEN-1:0]        hi_q;
   logic [XLEN-1:0]        lo_q;
   logic                   done_q;

   logic                   signed_op;
   logic                   div_op;
   logic                   sa;
   logic                   sb;
   logic [XLEN-1:0]        abs_a;
   logic [XLEN-1:0]        abs_b;

   logic [XLEN:0]          mul_sum;
   logic [2*XLEN-1:0]      prod_d;
   logic [XLEN:0]          div_trial;
   logic [XLEN-1:0]        rem_d;
   logic [XLEN-1:0]        quot_d;

   logic [2*XLEN-1:0]      prod_fix;
   logic [XLEN-1:0]        quot_fix;
   logic [XLEN-1:0]        rem_fix;

   assign signed_op = (eop == MDU_MULT) || (eop == MDU_DIV);
   assign div_op    = (eop == MDU_DIV)  || (eop == MDU_DIVU);
   assign sa        = signed_op & ea[XLEN-1];
   assign sb        = signed_op & eb[XLEN-1];

   pipemdu_signfix #(.W(XLEN)) u_abs_a (.a_i(ea), .neg_i(sa), .y_o(abs_a));
   pipemdu_signfix #(.W(XLEN)) u_abs_b (.a_i(eb), .neg_i(sb), .y_o(abs_b));

   // Shift-add step: multiplier sits in the low half and is consumed LSB first.
   assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]}
                  + ({1'b0, opb_q} & {(XLEN+1){prod_q[0]}});
   assign prod_d  = {mul_sum, prod_q[XLEN-1:1]};

   // Restoring step: a negative trial difference keeps the shifted remainder.
   assign div_trial = {rem_q, quot_q[XLEN-1]} - {1'b0, opb_q};
   assign rem_d     = div_trial[XLEN] ? {rem_q[XLEN-2:0], quot_q[XLEN-1]}
                                      : div_trial[XLEN-1:0];
   assign quot_d    = {quot_q[XLEN-2:0], ~div_trial[XLEN]};

   pipemdu_signfix #(.W(2*XLEN)) u_fix_p (.a_i(prod_q), .neg_i(negq_q), .y_o(prod_fix));
   pipemdu_signfix #(.W(XLEN))   u_fix_q (.a_i(quot_q), .neg_i(negq_q), .y_o(quot_fix));
   pipemdu_signfix #(.W(XLEN))   u_fix_r (.a_i(rem_q),  .neg_i(negr_q), .y_o(rem_fix));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         prod_q  <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         opb_q   <= '0;
         isdiv_q <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         div0_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (estart) begin
                  isdiv_q <= div_op;
                  negq_q  <= sa ^ sb;
                  negr_q  <= sa;
                  div0_q  <= (eb == '0);
                  opb_q   <= div_op ? abs_b : abs_a;
                  prod_q  <= {{XLEN{1'b0}}, abs_b};
                  rem_q   <= '0;
                  quot_q  <= abs_a;
                  cnt_q   <= MDU_CNT_W'(MDU_ITER - 1);
                  state_q <= ST_CALC;
               end else begin
                  if (ewhi) hi_q <= ea;
                  if (ewlo) lo_q <= ea;
               end
            end
            ST_CALC: begin
               if (isdiv_q) begin
                  rem_q  <= rem_d;
                  quot_q <= quot_d;
               end else begin
                  prod_q <= prod_d;
               end
               if (cnt_q == '0) state_q <= ST_FIX;
               else             cnt_q   <= cnt_q - {{(MDU_CNT_W-1){1'b0}}, 1'b1};
            end
            ST_FIX: begin
               // Divide by zero overrides only LO; the remainder path already yields ea.
               if (isdiv_q) begin
                  lo_q <= div0_q ? DIV0_Q : quot_fix;
                  hi_q <= rem_fix;
               end else begin
                  lo_q <= prod_fix[XLEN-1:0];
                  hi_q <= prod_fix[2*XLEN-1:XLEN];
               end
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign hi      = hi_q;
   assign lo      = lo_q;
   assign done    = done_q;
   assign busy    = (state_q != ST_IDLE);
   assign mdstall = busy & dneed;

endmodule

// File: tb/tb_pipemdu.sv
// Directed self-checking bench for pipemdu with hand-computed HI/LO results.
module tb_pipemdu;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        estart = 1'b0;
   logic [1:0]  eop = 2'b00;
   logic [31:0] ea = '0;
   logic [31:0] eb = '0;
   logic        ewhi = 1'b0;
   logic        ewlo = 1'b0;
   logic        dneed = 1'b0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        mdstall;

   int checks = 0;
   int errors = 0;

   pipemdu #(.XLEN(32)) dut (
      .clock(clock), .resetn(resetn), .estart(estart), .eop(eop),
      .ea(ea), .eb(eb), .ewhi(ewhi), .ewlo(ewlo), .dneed(dneed),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .mdstall(mdstall)
   );

   always #5 clock = ~clock;

   // Starts one operation and observes 37 cycles: busy count, done count,
   // cycle of the first done pulse and HI/LO seen in that cycle.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int nbusy, output int ndone, output int dk,
                         output logic [31:0] rhi, output logic [31:0] rlo);
      @(negedge clock);
      estart = 1'b1; eop = op; ea = a; eb = b;
      nbusy = 0; ndone = 0; dk = -1; rhi = 'x; rlo = 'x;
      for (int k = 1; k <= 37; k++) begin
         @(negedge clock);
         estart = 1'b0;
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (dk < 0) begin
               dk = k; rhi = hi; rlo = lo;
            end
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
      checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      resetn = 1'b1;
      @(negedge clock);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
   endtask

   task automatic test_multu_max();
      int nb, nd, dk; logic [31:0] rh, rl;
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, nd, dk, rh, rl);
      checks++; if (rh !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want %h", rh, 32'hFFFF_FFFE); end
      checks++; if (rl !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want %h", rl, 32'h1); end
      checks++; if (nd !== 1)  begin errors++; $display("FAIL multu_done_count got %0d want 1", nd); end
      checks++; if (nb !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", nb); end
      checks++; if (dk !== 34) begin errors++; $display("FAIL multu_latency got %0d want 34", dk); end
   endtask

   task automatic test_mult_signed();
      int nb, nd, dk; logic [31:0] rh, rl;
      run_op(2'b00, 32'hFFFF_FFF9, 32'd6, nb, nd, dk, rh, rl);
      checks++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi got %h want %h", rh, 32'hFFFF_FFFF); end
      checks++; if (rl !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mult_neg_lo got %h want %h", rl, 32'hFFFF_FFD6); end
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, nb, nd, dk, rh, rl);
      checks++; if (rh !== 32'h4000_0000) begin errors++; $display("FAIL mult_min_hi got %h want %h", rh, 32'h4000_0000); end
      checks++; if (rl !== 32'h0) begin errors++; $display("FAIL mult_min_lo got %h want %h", rl, 32'h0); end
   endtask

   task automatic test_divide();
      int nb, nd, dk; logic [31:0] rh, rl;
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, nb, nd, dk, rh, rl);
      checks++; if (rl !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got %h want %h", rl, 32'hFFFF_FFFD); end
      checks++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got %h want %h", rh, 32'hFFFF_FFFF); end
      checks++; if (dk !== 34) begin errors++; $display("FAIL div_latency got %0d want 34", dk); end
      run_op(2'b11, 32'd100, 32'd7, nb, nd, dk, rh, rl);
      checks++; if (rl !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want %h", rl, 32'd14); end
      checks++; if (rh !== 32'd2)  begin errors++; $display("FAIL divu_hi got %h want %h", rh, 32'd2); end
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, nb, nd, dk, rh, rl);
      checks++; if (rl !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negb_lo got %h want %h", rl, 32'hFFFF_FFFD); end
      checks++; if (rh !== 32'd1) begin errors++; $display("FAIL div_negb_hi got %h want %h", rh, 32'd1); end
   endtask

   task automatic test_div_corner();
      int nb, nd, dk; logic [31:0] rh, rl;
      run_op(2'b10, 32'd5, 32'd0, nb, nd, dk, rh, rl);
      checks++; if (rl !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got %h want %h", rl, 32'hFFFF_FFFF); end
      checks++; if (rh !== 32'd5) begin errors++; $display("FAIL div0_hi got %h want %h", rh, 32'd5); end
      checks++; if (dk !== 34) begin errors++; $display("FAIL div0_latency got %0d want 34", dk); end
      run_op(2'b10, 32'hFFFF_FFF9, 32'd0, nb, nd, dk, rh, rl);
      checks++; if (rl !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_neg_lo got %h want %h", rl, 32'hFFFF_FFFF); end
      checks++; if (rh !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div0_neg_hi got %h want %h", rh, 32'hFFFF_FFF9); end
      run_op(2'b11, 32'd9, 32'd0, nb, nd, dk, rh, rl);
      checks++; if (rl !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got %h want %h", rl, 32'hFFFF_FFFF); end
      checks++; if (rh !== 32'd9) begin errors++; $display("FAIL divu0_hi got %h want %h", rh, 32'd9); end
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, nb, nd, dk, rh, rl);
      checks++; if (rl !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want %h", rl, 32'h8000_0000); end
      checks++; if (rh !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want %h", rh, 32'h0); end
   endtask

   task automatic test_stall();
      @(negedge clock);
      estart = 1'b1; eop = 2'b01; ea = 32'd3; eb = 32'd4; dneed = 1'b1;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clock);
         estart = 1'b0;
         checks++;
         if (mdstall !== (k <= 33)) begin
            errors++; $display("FAIL stall_dneed cycle %0d got %b want %b", k, mdstall, (k <= 33));
         end
      end
      dneed = 1'b0;
      @(negedge clock);
      estart = 1'b1; eop = 2'b00; ea = 32'd3; eb = 32'd4;
      for (int k = 1; k <= 35; k++) begin
         @(negedge clock);
         estart = 1'b0;
         if (k == 10) begin
            checks++; if (mdstall !== 1'b0) begin errors++; $display("FAIL stall_nodneed got %b want 0", mdstall); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy_mid got %b want 1", busy); end
         end
      end
   endtask

   task automatic test_move();
      logic [31:0] rl; int dk;
      @(negedge clock);
      ewhi = 1'b1; ea = 32'h0000_1234;
      @(negedge clock);
      ewhi = 1'b0;
      checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi got %h want %h", hi, 32'h1234); end
      ewlo = 1'b1; ea = 32'h0000_5678;
      @(negedge clock);
      ewlo = 1'b0;
      checks++; if (lo !== 32'h0000_5678) begin errors++; $display("FAIL mtlo got %h want %h", lo, 32'h5678); end
      checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mtlo_hi_kept got %h want %h", hi, 32'h1234); end
      // Start and a move in the same cycle: the move must be lost.
      estart = 1'b1; eop = 2'b01; ea = 32'd3; eb = 32'd5; ewhi = 1'b1;
      @(negedge clock);
      estart = 1'b0; ewhi = 1'b0;
      checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL start_vs_mthi_hi got %h want %h", hi, 32'h1234); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_vs_mthi_busy got %b want 1", busy); end
      dk = -1; rl = 'x;
      for (int k = 2; k <= 40; k++) begin
         @(negedge clock);
         if (done && dk < 0) begin dk = k; rl = lo; end
      end
      checks++; if (rl !== 32'd15) begin errors++; $display("FAIL start_vs_mthi_lo got %h want %h", rl, 32'd15); end
   endtask

   task automatic test_back_to_back();
      int dk; logic [31:0] rl, rh;
      @(negedge clock);
      estart = 1'b1; eop = 2'b11; ea = 32'd100; eb = 32'd7;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clock);
         estart = 1'b0;
      end
      @(negedge clock);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", done); end
      checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_first_lo got %h want %h", lo, 32'd14); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_done_cycle got %b want 0", busy); end
      estart = 1'b1; eop = 2'b01; ea = 32'd6; eb = 32'd7;
      @(negedge clock);
      estart = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got %b want 1", busy); end
      dk = -1; rl = 'x; rh = 'x;
      for (int k = 2; k <= 40; k++) begin
         @(negedge clock);
         if (done && dk < 0) begin dk = k; rl = lo; rh = hi; end
      end
      checks++; if (rl !== 32'd42) begin errors++; $display("FAIL b2b_second_lo got %h want %h", rl, 32'd42); end
      checks++; if (rh !== 32'd0) begin errors++; $display("FAIL b2b_second_hi got %h want %h", rh, 32'd0); end
      checks++; if (dk !== 34) begin errors++; $display("FAIL b2b_second_latency got %0d want 34", dk); end
   endtask

   task automatic test_reset_mid();
      int nd, nb, dk; logic [31:0] rh, rl;
      @(negedge clock);
      estart = 1'b1; eop = 2'b10; ea = 32'hFFFF_FFF9; eb = 32'd2;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         estart = 1'b0;
      end
      resetn = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
      checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL rst_mid_hi got %h want %h", hi, 32'h0); end
      checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL rst_mid_lo got %h want %h", lo, 32'h0); end
      @(negedge clock);
      resetn = 1'b1;
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (done) nd++;
      end
      checks++; if (nd !== 0) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", nd); end
      run_op(2'b01, 32'd3, 32'd4, nb, nd, dk, rh, rl);
      checks++; if (rl !== 32'd12) begin errors++; $display("FAIL rst_after_multu_lo got %h want %h", rl, 32'd12); end
      checks++; if (rh !== 32'd0)  begin errors++; $display("FAIL rst_after_multu_hi got %h want %h", rh, 32'd0); end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_mult_signed();
      test_divide();
      test_div_corner();
      test_stall();
      test_move();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
